// File: rtl/bar_to_foo_unpacker.sv
// Unpacks one packed bar word into BEATS foo slices over valid/ready.
// The next word loads on the last beat's handshake, so streaming has no bubbles.
module bar_to_foo_unpacker #(
    parameter int IN_W      = 21,
    parameter int OUT_W     = 3,
    parameter int MSB_FIRST = 0,
    parameter int CNT_W     = 16,
    localparam int BEATS    = IN_W / OUT_W,
    localparam int IDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bar_valid,
    output logic             bar_ready,
    input  logic [IN_W-1:0]  bar,
    output logic             foo_valid,
    input  logic             foo_ready,
    output logic [OUT_W-1:0] foo,
    output logic [IDX_W-1:0] foo_idx,
    output logic             foo_last,
    output logic             busy,
    output logic [CNT_W-1:0] words_done
);

    if ((IN_W % OUT_W) != 0) begin : g_width_check
        $error("IN_W must be a multiple of OUT_W");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IN_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             ready_en_q;

    logic             at_last;
    logic [OUT_W-1:0] slice;
    logic [IN_W-1:0]  shifted;
    int               shamt;

    assign at_last    = (idx_q == IDX_W'(BEATS - 1));
    assign words_done = wd_q;

    // Select the current beat's slice out of the held word.
    always_comb begin
        shamt = 0;
        if (MSB_FIRST != 0) begin
            shamt = IN_W - ((int'(idx_q) + 1) * OUT_W);
        end else begin
            shamt = int'(idx_q) * OUT_W;
        end
        shifted = hold_q >> shamt;
        slice   = shifted[OUT_W-1:0];
    end

    // Next-state, handshake and output decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        wd_d      = wd_q;
        bar_ready = 1'b0;
        foo_valid = 1'b0;
        foo       = '0;
        foo_idx   = '0;
        foo_last  = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                bar_ready = ready_en_q;
                if (bar_valid && ready_en_q) begin
                    hold_d  = bar;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                foo_valid = 1'b1;
                foo       = slice;
                foo_idx   = idx_q;
                foo_last  = at_last;
                busy      = 1'b1;
                if (foo_ready) begin
                    if (!at_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        wd_d      = wd_q + CNT_W'(1);
                        bar_ready = 1'b1;
                        if (bar_valid) begin
                            hold_d = bar;
                            idx_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Input acceptance is held off until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // State, beat index, held word and delivered-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_bar_to_foo_unpacker.sv
// Scoreboard bench for bar_to_foo_unpacker: an LSB-first instance and an
// MSB-first instance with a 2-bit counter share the same stimulus.
module tb_bar_to_foo_unpacker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bar_valid = 1'b0;
    logic [20:0] bar = '0;
    logic        foo_ready = 1'b0;

    logic        a_bar_ready, a_foo_valid, a_foo_last, a_busy;
    logic [2:0]  a_foo, a_foo_idx;
    logic [15:0] a_wd;
    logic        b_bar_ready, b_foo_valid, b_foo_last, b_busy;
    logic [2:0]  b_foo, b_foo_idx;
    logic [1:0]  b_wd;

    always #5 clk = ~clk;

    bar_to_foo_unpacker #(.IN_W(21), .OUT_W(3), .MSB_FIRST(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bar_valid(bar_valid), .bar_ready(a_bar_ready),
        .bar(bar), .foo_valid(a_foo_valid), .foo_ready(foo_ready), .foo(a_foo),
        .foo_idx(a_foo_idx), .foo_last(a_foo_last), .busy(a_busy), .words_done(a_wd)
    );

    bar_to_foo_unpacker #(.IN_W(21), .OUT_W(3), .MSB_FIRST(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bar_valid(bar_valid), .bar_ready(b_bar_ready),
        .bar(bar), .foo_valid(b_foo_valid), .foo_ready(foo_ready), .foo(b_foo),
        .foo_idx(b_foo_idx), .foo_last(b_foo_last), .busy(b_busy), .words_done(b_wd)
    );

    typedef struct {
        logic [2:0] foo;
        logic [2:0] idx;
        logic       last;
    } beat_t;

    beat_t       qa[$];
    beat_t       qb[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_wd = 0;
    logic [20:0] vw[4];
    logic [2:0]  vb[4][7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Offer word i until accepted; on acceptance push the expected beats.
    task automatic send(input int i);
        int  n;
        bit  ok;
        beat_t e;
        n = 0;
        ok = 1'b0;
        bar = vw[i];
        bar_valid = 1'b1;
        while (n < 60 && !ok) begin
            @(negedge clk);
            if (a_bar_ready) ok = 1'b1;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout word %0d actual 0 required 1", i);
            bar_valid = 1'b0;
            return;
        end
        for (int k = 0; k < 7; k++) begin
            e.foo = vb[i][k];
            e.idx = 3'(k);
            e.last = (k == 6);
            qa.push_back(e);
            e.foo = vb[i][6-k];
            qb.push_back(e);
        end
        @(posedge clk);
        #1;
        bar_valid = 1'b0;
        chk("beat0_valid", 32'(a_foo_valid), 32'd1);
        chk("beat0_idx", 32'(a_foo_idx), 32'd0);
    endtask

    // Monitor: pop and compare on every output handshake; track words_done.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            chk("wd_a", 32'(a_wd), 32'(exp_wd % 65536));
            chk("wd_b", 32'(b_wd), 32'(exp_wd % 4));
            if (!a_foo_valid) begin
                chk("idle_zero", 32'({a_foo, a_foo_idx, a_foo_last}), 32'd0);
            end
            if (a_foo_valid && foo_ready) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat_a actual %0h required none", a_foo);
                end else begin
                    e = qa.pop_front();
                    chk("foo_a", 32'(a_foo), 32'(e.foo));
                    chk("idx_a", 32'(a_foo_idx), 32'(e.idx));
                    chk("last_a", 32'(a_foo_last), 32'(e.last));
                    if (e.last) exp_wd++;
                end
            end
            if (b_foo_valid && foo_ready) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat_b actual %0h required none", b_foo);
                end else begin
                    e = qb.pop_front();
                    chk("foo_b", 32'(b_foo), 32'(e.foo));
                    chk("idx_b", 32'(b_foo_idx), 32'(e.idx));
                    chk("last_b", 32'(b_foo_last), 32'(e.last));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        int pos;

        vw[0] = 21'h1F58D1;
        vb[0] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        vw[1] = {3'd1, 3'd6, 3'd3, 3'd2, 3'd5, 3'd0, 3'd7};
        vb[1] = '{3'd7, 3'd0, 3'd5, 3'd2, 3'd3, 3'd6, 3'd1};
        vw[2] = 21'h155555;
        vb[2] = '{3'd5, 3'd2, 3'd5, 3'd2, 3'd5, 3'd2, 3'd5};
        vw[3] = 21'h0AAAAA;
        vb[3] = '{3'd2, 3'd5, 3'd2, 3'd5, 3'd2, 3'd5, 3'd2};

        // reset state
        #2;
        chk("rst_valid", 32'(a_foo_valid), 32'd0);
        chk("rst_ready", 32'(a_bar_ready), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_wd", 32'(a_wd), 32'd0);
        chk("rst_foo", 32'({a_foo, a_foo_idx, a_foo_last}), 32'd0);
        #11;
        rst_n = 1'b1;
        #1;
        chk("rel_ready0", 32'(a_bar_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rel_ready1", 32'(a_bar_ready), 32'd1);

        // single word, both slice orders
        foo_ready = 1'b1;
        send(0);
        repeat (10) @(negedge clk);
        chk("t1_wd", 32'(a_wd), 32'd1);

        // back-to-back: 14 gapless beats, one bar_ready pulse at beat 6
        @(posedge clk);
        #1;
        pulses = 0;
        pos = -1;
        fork
            begin
                send(1);
                send(2);
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!a_foo_valid && n < 60);
                for (int b = 0; b < 14; b++) begin
                    if (b > 0) @(negedge clk);
                    chk("b2b_valid", 32'(a_foo_valid), 32'd1);
                    if (b < 13 && a_bar_ready) begin
                        pulses++;
                        pos = b;
                    end
                end
            end
        join
        chk("b2b_pulses", 32'(pulses), 32'd1);
        chk("b2b_pos", 32'(pos), 32'd6);
        repeat (4) @(negedge clk);

        // backpressure at beat 2 for 3 cycles
        @(posedge clk);
        #1;
        fork
            send(0);
            begin
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!(a_foo_valid && a_foo_idx == 3'd2) && n < 60);
                foo_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(a_foo_valid), 32'd1);
                    chk("stall_foo", 32'(a_foo), 32'd3);
                    chk("stall_idx", 32'(a_foo_idx), 32'd2);
                    chk("stall_last", 32'(a_foo_last), 32'd0);
                    chk("stall_ready", 32'(a_bar_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                foo_ready = 1'b1;
            end
        join
        repeat (10) @(negedge clk);
        chk("t4_wd", 32'(a_wd), 32'd4);

        // reset mid-word at beat 4
        @(posedge clk);
        #1;
        fork
            send(1);
            begin
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!(a_foo_valid && a_foo_idx == 3'd4) && n < 60);
                #2;
                rst_n = 1'b0;
                #1;
                chk("mid_valid_a", 32'(a_foo_valid), 32'd0);
                chk("mid_valid_b", 32'(b_foo_valid), 32'd0);
                chk("mid_wd_a", 32'(a_wd), 32'd0);
                chk("mid_wd_b", 32'(b_wd), 32'd0);
                chk("mid_ready", 32'(a_bar_ready), 32'd0);
                chk("mid_busy", 32'(a_busy), 32'd0);
                qa.delete();
                qb.delete();
                exp_wd = 0;
            end
        join
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready0", 32'(a_bar_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rel_ready1", 32'(a_bar_ready), 32'd1);

        // five words: 2-bit counter runs 1,2,3,0,1
        for (int i = 0; i < 5; i++) send(i % 4);
        repeat (12) @(negedge clk);
        chk("wrap_wd_a", 32'(a_wd), 32'd5);
        chk("wrap_wd_b", 32'(b_wd), 32'd1);
        chk("sb_empty", 32'(qa.size() + qb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
